tb_test_monitor: RTL and testbench

Parametrised, clocked test-verdict monitor for the IP test benches. It watches the progress, pass and fail test registers of up to NUM_CH DUT channels (for example one per core or per test-register block). It reports progress changes as a one-event-per-cycle stream and decides a single verdict: FAIL, PASS, STALL or MAX_CLOCKS. It then signals completion after a programmable drain. It sits in the testbench between the DUT test registers and the $display/$finish logic, replacing ad-hoc per-bench monitoring.

---
 rtl/tb_test_monitor.sv | 212 +++++++++++++++++++++
 tb/tb_tb_test_monitor.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tb_test_monitor.sv
// Test-verdict monitor: streams per-channel progress changes and settles a single
// PASS/FAIL/STALL/MAX_CLOCKS verdict, raising done after a programmable drain.
module tb_test_monitor #(
  parameter int unsigned NUM_CH       = 1,
  parameter int unsigned CH_W         = 4,
  parameter logic [31:0] MAX_CLOCKS   = 32'd100000,
  parameter logic [31:0] STALL_CLOCKS = 32'd0,
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter bit          PASS_ALL     = 1'b1
) (
  input  logic                 sim_clk,
  input  logic                 sim_rst,
  input  logic [32*NUM_CH-1:0] test_progress,
  input  logic [32*NUM_CH-1:0] test_pass,
  input  logic [32*NUM_CH-1:0] test_fail,
  output logic                 prog_valid,
  output logic [CH_W-1:0]      prog_ch,
  output logic [31:0]          prog_value,
  output logic [2:0]           verdict,
  output logic [CH_W-1:0]      verdict_ch,
  output logic [31:0]          verdict_code,
  output logic                 done,
  output logic [31:0]          cycle_count
);

  typedef enum logic [1:0] {ST_PRIME, ST_RUN, ST_DRAIN, ST_DONE} state_e;
  typedef enum logic [2:0] {
    V_RUN = 3'd0, V_PASS = 3'd1, V_FAIL = 3'd2, V_MAX = 3'd3, V_STALL = 3'd4
  } verdict_e;

  state_e            state_q, state_d;
  logic [31:0]       shadow_q    [NUM_CH];
  logic [31:0]       shadow_d    [NUM_CH];
  logic [31:0]       pass_code_q [NUM_CH];
  logic [31:0]       pass_code_d [NUM_CH];
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [NUM_CH-1:0] passed_q, passed_d;
  logic [31:0]       stall_q, stall_d;
  logic [31:0]       drain_q, drain_d;
  logic [31:0]       cycle_q, cycle_d;
  logic              prog_valid_q, prog_valid_d;
  logic [CH_W-1:0]   prog_ch_q, prog_ch_d;
  logic [31:0]       prog_value_q, prog_value_d;
  verdict_e          verdict_q, verdict_d;
  logic [CH_W-1:0]   verdict_ch_q, verdict_ch_d;
  logic [31:0]       verdict_code_q, verdict_code_d;
  logic              done_q, done_d;

  logic [NUM_CH-1:0] change;
  logic              emit_found, fail_found, pass_found, all_passed, hit;
  logic [CH_W-1:0]   fail_idx, pass_idx;
  logic [31:0]       fail_code, pass_code;

  always_comb begin
    state_d        = state_q;
    shadow_d       = shadow_q;
    pass_code_d    = pass_code_q;
    pending_d      = pending_q;
    passed_d       = passed_q;
    stall_d        = stall_q;
    drain_d        = drain_q;
    cycle_d        = cycle_q;
    prog_valid_d   = 1'b0;
    prog_ch_d      = prog_ch_q;
    prog_value_d   = prog_value_q;
    verdict_d      = verdict_q;
    verdict_ch_d   = verdict_ch_q;
    verdict_code_d = verdict_code_q;
    done_d         = done_q;
    change         = '0;
    emit_found     = 1'b0;
    fail_found     = 1'b0;
    pass_found     = 1'b0;
    all_passed     = 1'b1;
    hit            = 1'b0;
    fail_idx       = '0;
    pass_idx       = '0;
    fail_code      = '0;
    pass_code      = '0;

    unique case (state_q)
      ST_PRIME: begin
        for (int unsigned i = 0; i < NUM_CH; i++) shadow_d[i] = test_progress[32*i +: 32];
        state_d = ST_RUN;
      end
      ST_RUN, ST_DRAIN: begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          if (test_progress[32*i +: 32] != shadow_q[i]) begin
            change[i]   = 1'b1;
            shadow_d[i] = test_progress[32*i +: 32];
          end
        end
        pending_d = pending_q | change;
        // The event carries the post-change shadow, so a same-edge change is folded in.
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          if (pending_q[i] && !emit_found) begin
            emit_found   = 1'b1;
            pending_d[i] = 1'b0;
            prog_valid_d = 1'b1;
            prog_ch_d    = CH_W'(i);
            prog_value_d = shadow_d[i];
          end
        end
        stall_d = (|change) ? '0 : ((stall_q == '1) ? stall_q : stall_q + 32'd1);
        cycle_d = cycle_q + 32'd1;

        if (state_q == ST_RUN) begin
          for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (test_fail[32*i +: 32] != '0 && !fail_found) begin
              fail_found = 1'b1;
              fail_idx   = CH_W'(i);
              fail_code  = test_fail[32*i +: 32];
            end
            if (test_pass[32*i +: 32] != '0) begin
              passed_d[i]    = 1'b1;
              pass_code_d[i] = test_pass[32*i +: 32];
            end
            if (passed_d[i] && !pass_found) begin
              pass_found = 1'b1;
              pass_idx   = CH_W'(i);
              pass_code  = pass_code_d[i];
            end
            all_passed = all_passed & passed_d[i];
          end

          hit = 1'b1;
          if (fail_found) begin
            verdict_d      = V_FAIL;
            verdict_ch_d   = fail_idx;
            verdict_code_d = fail_code;
          end else if (PASS_ALL ? all_passed : pass_found) begin
            verdict_d      = V_PASS;
            verdict_ch_d   = pass_idx;
            verdict_code_d = pass_code;
          end else if (STALL_CLOCKS != '0 && stall_q == STALL_CLOCKS) begin
            verdict_d      = V_STALL;
            verdict_ch_d   = '0;
            verdict_code_d = cycle_q;
          end else if (MAX_CLOCKS != '0 && cycle_q == MAX_CLOCKS) begin
            verdict_d      = V_MAX;
            verdict_ch_d   = '0;
            verdict_code_d = cycle_q;
          end else begin
            hit = 1'b0;
          end

          if (hit) begin
            if (DRAIN_CYCLES == 0) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_DRAIN;
              drain_d = '0;
            end
          end
        end else if (drain_q == 32'(DRAIN_CYCLES - 1)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q + 32'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge sim_clk or posedge sim_rst) begin
    if (sim_rst) begin
      state_q        <= ST_PRIME;
      shadow_q       <= '{default: '0};
      pass_code_q    <= '{default: '0};
      pending_q      <= '0;
      passed_q       <= '0;
      stall_q        <= '0;
      drain_q        <= '0;
      cycle_q        <= '0;
      prog_valid_q   <= 1'b0;
      prog_ch_q      <= '0;
      prog_value_q   <= '0;
      verdict_q      <= V_RUN;
      verdict_ch_q   <= '0;
      verdict_code_q <= '0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      shadow_q       <= shadow_d;
      pass_code_q    <= pass_code_d;
      pending_q      <= pending_d;
      passed_q       <= passed_d;
      stall_q        <= stall_d;
      drain_q        <= drain_d;
      cycle_q        <= cycle_d;
      prog_valid_q   <= prog_valid_d;
      prog_ch_q      <= prog_ch_d;
      prog_value_q   <= prog_value_d;
      verdict_q      <= verdict_d;
      verdict_ch_q   <= verdict_ch_d;
      verdict_code_q <= verdict_code_d;
      done_q         <= done_d;
    end
  end

  assign prog_valid   = prog_valid_q;
  assign prog_ch      = prog_ch_q;
  assign prog_value   = prog_value_q;
  assign verdict      = verdict_q;
  assign verdict_ch   = verdict_ch_q;
  assign verdict_code = verdict_code_q;
  assign done         = done_q;
  assign cycle_count  = cycle_q;

endmodule

// File: tb/tb_tb_test_monitor.sv
// Bench for tb_test_monitor: two configurations share stimulus; a spec-level
// model predicts events and verdicts, directed tasks cover the named scenarios.
module tb_tb_test_monitor;
  localparam int unsigned N = 4;

  logic            sim_clk = 1'b0;
  logic            sim_rst;
  logic [32*N-1:0] prog, pass, fail;

  logic        pv    [2];
  logic [3:0]  pch   [2];
  logic [31:0] pval  [2];
  logic [2:0]  verd  [2];
  logic [3:0]  vch   [2];
  logic [31:0] vcode [2];
  logic        done  [2];
  logic [31:0] cyc   [2];

  int errors = 0;
  int checks = 0;

  always #5 sim_clk = ~sim_clk;

  // A: all-pass, stall 20, max 1000, drain 2.  B: any-pass, no stall, max 300, no drain.
  tb_test_monitor #(.NUM_CH(N), .CH_W(4), .MAX_CLOCKS(32'd1000), .STALL_CLOCKS(32'd20),
                    .DRAIN_CYCLES(2), .PASS_ALL(1'b1)) dut_a (
    .sim_clk(sim_clk), .sim_rst(sim_rst), .test_progress(prog), .test_pass(pass),
    .test_fail(fail), .prog_valid(pv[0]), .prog_ch(pch[0]), .prog_value(pval[0]),
    .verdict(verd[0]), .verdict_ch(vch[0]), .verdict_code(vcode[0]), .done(done[0]),
    .cycle_count(cyc[0]));

  tb_test_monitor #(.NUM_CH(N), .CH_W(4), .MAX_CLOCKS(32'd300), .STALL_CLOCKS(32'd0),
                    .DRAIN_CYCLES(0), .PASS_ALL(1'b0)) dut_b (
    .sim_clk(sim_clk), .sim_rst(sim_rst), .test_progress(prog), .test_pass(pass),
    .test_fail(fail), .prog_valid(pv[1]), .prog_ch(pch[1]), .prog_value(pval[1]),
    .verdict(verd[1]), .verdict_ch(vch[1]), .verdict_code(vcode[1]), .done(done[1]),
    .cycle_count(cyc[1]));

  // Reference model state (phase: 0 prime, 1 run, 2 drain, 3 done)
  int          m_phase [2];
  int          m_drain [2];
  logic [31:0] m_last  [2][N];
  bit          m_pend  [2][N];
  bit          m_passed[2][N];
  logic [31:0] m_pcode [2][N];
  logic [31:0] m_stall [2];
  logic [31:0] m_cyc   [2];
  bit          e_pv    [2];
  logic [3:0]  e_pch   [2];
  logic [31:0] e_pval  [2];
  logic [2:0]  e_verd  [2];
  logic [3:0]  e_vch   [2];
  logic [31:0] e_vcode [2];
  bit          e_done  [2];

  task automatic model_reset(input int k);
    m_phase[k] = 0; m_drain[k] = 0; m_stall[k] = '0; m_cyc[k] = '0;
    for (int c = 0; c < N; c++) begin
      m_last[k][c] = '0; m_pend[k][c] = 0; m_passed[k][c] = 0; m_pcode[k][c] = '0;
    end
    e_pv[k] = 0; e_pch[k] = '0; e_pval[k] = '0; e_verd[k] = '0; e_vch[k] = '0;
    e_vcode[k] = '0; e_done[k] = 0;
  endtask

  task automatic model_step(input int k);
    logic [31:0] mx, st;
    int dr, j, fi, pi;
    bit pa, anychg, allp, anyp, got;
    mx = (k == 0) ? 32'd1000 : 32'd300;
    st = (k == 0) ? 32'd20 : 32'd0;
    dr = (k == 0) ? 2 : 0;
    pa = (k == 0);
    e_pv[k] = 0;
    if (m_phase[k] == 0) begin
      for (int c = 0; c < N; c++) m_last[k][c] = prog[32*c +: 32];
      m_phase[k] = 1;
    end else if (m_phase[k] == 1 || m_phase[k] == 2) begin
      j = -1;
      for (int c = N - 1; c >= 0; c--) if (m_pend[k][c]) j = c;
      anychg = 0;
      for (int c = 0; c < N; c++) begin
        if (prog[32*c +: 32] != m_last[k][c]) begin
          m_last[k][c] = prog[32*c +: 32]; m_pend[k][c] = 1; anychg = 1;
        end
      end
      if (j >= 0) begin
        e_pv[k] = 1; e_pch[k] = 4'(j); e_pval[k] = m_last[k][j]; m_pend[k][j] = 0;
      end
      if (m_phase[k] == 1) begin
        fi = -1; pi = -1; allp = 1; anyp = 0;
        for (int c = N - 1; c >= 0; c--) if (fail[32*c +: 32] != 0) fi = c;
        for (int c = 0; c < N; c++)
          if (pass[32*c +: 32] != 0) begin m_passed[k][c] = 1; m_pcode[k][c] = pass[32*c +: 32]; end
        for (int c = N - 1; c >= 0; c--)
          if (m_passed[k][c]) begin anyp = 1; pi = c; end else allp = 0;
        got = 1;
        if (fi >= 0) begin
          e_verd[k] = 3'd2; e_vch[k] = 4'(fi); e_vcode[k] = fail[32*fi +: 32];
        end else if (pa ? allp : anyp) begin
          e_verd[k] = 3'd1; e_vch[k] = 4'(pi); e_vcode[k] = m_pcode[k][pi];
        end else if (st != 0 && m_stall[k] == st) begin
          e_verd[k] = 3'd4; e_vch[k] = '0; e_vcode[k] = m_cyc[k];
        end else if (mx != 0 && m_cyc[k] == mx) begin
          e_verd[k] = 3'd3; e_vch[k] = '0; e_vcode[k] = m_cyc[k];
        end else got = 0;
        if (got) begin
          if (dr == 0) begin m_phase[k] = 3; e_done[k] = 1; end
          else begin m_phase[k] = 2; m_drain[k] = dr; end
        end
      end else begin
        m_drain[k]--;
        if (m_drain[k] == 0) begin m_phase[k] = 3; e_done[k] = 1; end
      end
      if (anychg) m_stall[k] = '0;
      else if (m_stall[k] != 32'hFFFF_FFFF) m_stall[k]++;
      m_cyc[k]++;
    end
  endtask

  always @(posedge sim_clk or posedge sim_rst) begin
    if (sim_rst) begin model_reset(0); model_reset(1); end
    else begin model_step(0); model_step(1); end
  end

  task automatic apply_reset();
    @(negedge sim_clk);
    sim_rst = 1'b1; prog = '0; pass = '0; fail = '0;
    @(negedge sim_clk);
    sim_rst = 1'b0;
    @(negedge sim_clk);
  endtask

  task automatic test_reset();
    sim_rst = 1'b1; prog = '0; pass = '0; fail = '0;
    repeat (2) @(negedge sim_clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({pv[k], pch[k], pval[k], verd[k], vch[k], vcode[k], done[k], cyc[k]} !== '0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d got pv=%b verd=%0d done=%b cyc=%0d want all 0",
                 k, pv[k], verd[k], done[k], cyc[k]);
      end
    end
    sim_rst = 1'b0;
    prog[31:0] = 32'h7;
    @(negedge sim_clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({pv[k], verd[k], cyc[k]} !== '0) begin
        errors++;
        $display("FAIL prime_cycle dut%0d got pv=%b verd=%0d cyc=%0d want 0 0 0",
                 k, pv[k], verd[k], cyc[k]);
      end
    end
  endtask

  task automatic test_progress_random();
    int c;
    repeat (120) begin
      if ($urandom_range(3) != 0) begin
        c = $urandom_range(N - 1);
        prog[32*c +: 32] = $urandom();
        if ($urandom_range(2) == 0) begin
          c = $urandom_range(N - 1);
          prog[32*c +: 32] = $urandom();
        end
      end
      @(negedge sim_clk);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (pv[k] !== e_pv[k] || (e_pv[k] && (pch[k] !== e_pch[k] || pval[k] !== e_pval[k]))) begin
          errors++;
          $display("FAIL rand_event dut%0d got v=%b ch=%0d val=%h want v=%b ch=%0d val=%h",
                   k, pv[k], pch[k], pval[k], e_pv[k], e_pch[k], e_pval[k]);
        end
        checks++;
        if ({verd[k], vch[k], vcode[k], done[k], cyc[k]} !==
            {e_verd[k], e_vch[k], e_vcode[k], e_done[k], m_cyc[k]}) begin
          errors++;
          $display("FAIL rand_state dut%0d got verd=%0d done=%b cyc=%0d want verd=%0d done=%b cyc=%0d",
                   k, verd[k], done[k], cyc[k], e_verd[k], e_done[k], m_cyc[k]);
        end
      end
    end
  endtask

  task automatic test_same_edge();
    logic [31:0] v1, v3;
    repeat (5) @(negedge sim_clk);
    v1 = prog[63:32] + 32'd1;
    v3 = prog[127:96] + 32'd1;
    prog[63:32] = v1; prog[127:96] = v3;
    @(negedge sim_clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (pv[k] !== 1'b0) begin errors++; $display("FAIL same_edge_lat dut%0d got pv=%b want 0", k, pv[k]); end
    end
    @(negedge sim_clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({pv[k], pch[k], pval[k]} !== {1'b1, 4'd1, v1}) begin
        errors++;
        $display("FAIL same_edge_first dut%0d got v=%b ch=%0d val=%h want v=1 ch=1 val=%h", k, pv[k], pch[k], pval[k], v1);
      end
    end
    @(negedge sim_clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({pv[k], pch[k], pval[k]} !== {1'b1, 4'd3, v3}) begin
        errors++;
        $display("FAIL same_edge_second dut%0d got v=%b ch=%0d val=%h want v=1 ch=3 val=%h", k, pv[k], pch[k], pval[k], v3);
      end
    end
    @(negedge sim_clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (pv[k] !== 1'b0) begin errors++; $display("FAIL same_edge_idle dut%0d got pv=%b want 0", k, pv[k]); end
    end
  endtask

  task automatic test_pass_all();
    apply_reset();
    repeat (9) begin prog[31:0] = prog[31:0] + 32'd1; @(negedge sim_clk); end
    pass[31:0] = 32'h1; prog[31:0] = prog[31:0] + 32'd1;
    @(negedge sim_clk);
    checks++;
    if ({verd[1], vch[1], vcode[1], done[1]} !== {3'd1, 4'd0, 32'h1, 1'b1}) begin
      errors++;
      $display("FAIL pass_any dut1 got verd=%0d ch=%0d code=%h done=%b want 1 0 1 1", verd[1], vch[1], vcode[1], done[1]);
    end
    checks++;
    if (verd[0] !== 3'd0) begin errors++; $display("FAIL pass_all_early dut0 got verd=%0d want 0", verd[0]); end
    repeat (19) begin prog[31:0] = prog[31:0] + 32'd1; @(negedge sim_clk); end
    checks++;
    if (verd[0] !== 3'd0) begin errors++; $display("FAIL pass_all_wait dut0 got verd=%0d want 0", verd[0]); end
    checks++;
    if (pv[1] !== 1'b0) begin errors++; $display("FAIL done_frozen dut1 got pv=%b want 0", pv[1]); end
    pass[63:32] = 32'h2; pass[95:64] = 32'h3; pass[127:96] = 32'h4;
    @(negedge sim_clk);
    checks++;
    if ({verd[0], vch[0], vcode[0], done[0]} !== {3'd1, 4'd0, 32'h1, 1'b0}) begin
      errors++;
      $display("FAIL pass_all dut0 got verd=%0d ch=%0d code=%h done=%b want 1 0 1 0", verd[0], vch[0], vcode[0], done[0]);
    end
    @(negedge sim_clk);
    checks++;
    if (done[0] !== 1'b0) begin errors++; $display("FAIL drain_1 dut0 got done=%b want 0", done[0]); end
    @(negedge sim_clk);
    checks++;
    if ({done[0], verd[0]} !== {1'b1, 3'd1}) begin
      errors++; $display("FAIL drain_2 dut0 got done=%b verd=%0d want 1 1", done[0], verd[0]);
    end
  endtask

  task automatic test_fail_priority();
    apply_reset();
    pass[31:0] = 32'h5; fail[95:64] = 32'hBAD;
    @(negedge sim_clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({verd[k], vch[k], vcode[k]} !== {3'd2, 4'd2, 32'hBAD}) begin
        errors++;
        $display("FAIL fail_prio dut%0d got verd=%0d ch=%0d code=%h want 2 2 bad", k, verd[k], vch[k], vcode[k]);
      end
    end
  endtask

  task automatic test_stall_max();
    int ta, tb, tda;
    ta = -1; tb = -1; tda = -1;
    apply_reset();
    // t counts negedges after the priming edge; run edge r is observed at t = r + 1
    for (int t = 1; t <= 400; t++) begin
      if (ta < 0 && verd[0] != 3'd0) ta = t - 1;
      if (tda < 0 && done[0]) tda = t - 1;
      if (tb < 0 && verd[1] != 3'd0) tb = t - 1;
      if (ta >= 0 && tb >= 0 && tda >= 0) break;
      @(negedge sim_clk);
    end
    checks++;
    if ({verd[0], vch[0], vcode[0]} !== {3'd4, 4'd0, 32'd20} || ta != 21) begin
      errors++;
      $display("FAIL stall dut0 got verd=%0d code=%0d at run edge %0d want 4 20 at 21", verd[0], vcode[0], ta);
    end
    checks++;
    if (tda - ta != 2 || ta < 0) begin
      errors++; $display("FAIL stall_drain dut0 got done %0d edges after verdict want 2", tda - ta);
    end
    checks++;
    if ({verd[1], vch[1], vcode[1], done[1]} !== {3'd3, 4'd0, 32'd300, 1'b1} || tb != 301) begin
      errors++;
      $display("FAIL max_clocks dut1 got verd=%0d code=%0d at run edge %0d want 3 300 at 301", verd[1], vcode[1], tb);
    end
  endtask

  task automatic test_reset_mid_drain();
    apply_reset();
    fail[95:64] = 32'h7;
    @(negedge sim_clk);
    checks++;
    if ({verd[0], done[0]} !== {3'd2, 1'b0}) begin
      errors++; $display("FAIL pre_reset dut0 got verd=%0d done=%b want 2 0", verd[0], done[0]);
    end
    #2 sim_rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({done[k], verd[k], cyc[k], pv[k]} !== '0) begin
        errors++;
        $display("FAIL mid_drain_reset dut%0d got done=%b verd=%0d cyc=%0d want 0 0 0", k, done[k], verd[k], cyc[k]);
      end
    end
    @(negedge sim_clk);
    fail = '0; prog[63:32] = 32'h55; sim_rst = 1'b0;
    @(negedge sim_clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({pv[k], cyc[k], verd[k]} !== {1'b0, 32'd0, 3'd0}) begin
        errors++; $display("FAIL reprime dut%0d got pv=%b cyc=%0d verd=%0d want 0 0 0", k, pv[k], cyc[k], verd[k]);
      end
    end
    @(negedge sim_clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({pv[k], cyc[k], verd[k]} !== {1'b0, 32'd1, 3'd0}) begin
        errors++; $display("FAIL first_run dut%0d got pv=%b cyc=%0d verd=%0d want 0 1 0", k, pv[k], cyc[k], verd[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_progress_random();
    test_same_edge();
    test_pass_all();
    test_fail_priority();
    test_stall_max();
    test_reset_mid_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
